imem_fetch_ctrl: RTL

Instruction-fetch sequencer in front of the 256x16 word-addressed instruction memory. Owns the program counter, drives the memory's 8-bit address, captures the combinationally returned 16-bit instruction word, and hands instructions to decode through a 2-entry valid/ready buffer. Accepts redirects (branches, jumps, exceptions) from execute. Optionally short-circuits unconditional jumps at fetch.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_buf.sv | 70 +++++++
 rtl/imem_fetch_ctrl.sv | 74 +++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, opcode constant and buffer entry type for the instruction-fetch block.
package fetch_pkg;

    localparam int IW_W = 16;
    localparam int PC_W = 8;

    localparam logic [3:0] OPC_J = 4'b0010;

    typedef struct packed {
        logic [IW_W-1:0] iw;
        logic [PC_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO between fetch and decode; entry 0 is always the head, so head
// outputs come straight from a flop.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         valid,
    output logic         full
);

    fetch_entry_t     entry_q [DEPTH];
    fetch_entry_t     entry_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] wr_idx;
    logic             pop_ok;
    logic             push_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign valid = (count_q != '0);
    assign head  = entry_q[0];

    always_comb begin
        pop_ok  = pop && valid;
        push_ok = push && !flush && (!full || pop_ok);
        // Slot to write once the pop (if any) has shifted entry 1 into the head.
        wr_idx  = count_q - CNT_W'(pop_ok);
        entry_d = entry_q;
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            if (pop_ok) begin
                entry_d[0] = entry_q[1];
            end
            if (push_ok) begin
                if (wr_idx == '0) begin
                    entry_d[0] = push_entry;
                end else begin
                    entry_d[1] = push_entry;
                end
            end
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// PC sequencing, redirect arbitration and fetch-to-decode buffering for the 256x16 imem.
// Optional fetch-stage jump resolution: define IMEM_FETCH_PREDECODE_JUMP_EN.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 8'h00,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_addr,
    input  logic [IW_W-1:0] imem_iw,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [IW_W-1:0] inst,
    output logic [PC_W-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            fetch_en
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            pop;
    logic            push;
    logic            full;
    logic            is_jump;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    assign imem_addr  = pc_q;
    assign pop        = inst_valid && inst_ready;
    assign push       = fetch_en && !redirect_valid && (!full || pop);
    assign push_entry = '{iw: imem_iw, pc: pc_q};
    assign inst       = head.iw;
    assign inst_pc    = head.pc;

    always_comb begin
`ifdef IMEM_FETCH_PREDECODE_JUMP_EN
        is_jump = (imem_iw[15:12] == OPC_J);
`else
        is_jump = 1'b0;
`endif
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (push) begin
            pc_d = is_jump ? imem_iw[PC_W-1:0] : pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .valid      (inst_valid),
        .full       (full)
    );

endmodule
